// File: rtl/rx_ctrl_pkg.sv
// Shared types and default sizing for the UART receive sequencer.
package rx_ctrl_pkg;

   localparam int DEF_CLKS_PER_BIT = 10;
   localparam int DEF_DATA_BITS    = 8;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      START      = 3'd1,
      DATA       = 3'd2,
      STOP_CHK   = 3'd3,
      FRAME_EVAL = 3'd4,
      LOAD       = 3'd5
   } rx_state_t;

endpackage

// File: rtl/rx_bit_timer.sv
// Up-counter with synchronous clear, count enable and a run-time terminal
// value. With WRAP set the count returns to zero after the terminal value,
// otherwise it holds there until cleared.
module rx_bit_timer #(
   parameter int WIDTH = 4,
   parameter bit WRAP  = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   input  logic [WIDTH-1:0] terminal,
   output logic [WIDTH-1:0] count
);

   // Counter register: clear wins over enable, never steps past terminal.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         if (count == terminal) begin
            count <= WRAP ? '0 : count;
         end else begin
            count <= count + WIDTH'(1);
         end
      end else begin
         count <= count;
      end
   end

endmodule

// File: rtl/rx_seq_ctrl.sv
// Receive sequencer: times a UART frame from the start-bit detection,
// strobes the shift register at each bit centre (stop bit included), runs
// the stop-bit check and loads the data buffer on a clean frame.
// Optional feature macro: RX_START_VERIFY_EN (re-checks the line at the
// middle of the start bit and rejects glitches).
module rx_seq_ctrl
   import rx_ctrl_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int DATA_BITS    = DEF_DATA_BITS
) (
   input  logic clk,
   input  logic rst,
   input  logic start_bit_detected,
   input  logic serial_in_sync,
   input  logic framing_error,
   output logic shift_strobe,
   output logic sbc_clear,
   output logic sbc_enable,
   output logic load_buffer,
   output logic rx_busy,
   output logic glitch_reject
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS + 2);

   // Last clk_cnt value of the half start bit and of a full bit period.
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   // bit_cnt value just before the stop-bit strobe, and its hold value.
   localparam logic [BW-1:0] LAST_IDX  = BW'(DATA_BITS);
   localparam logic [BW-1:0] BIT_TERM  = BW'(DATA_BITS + 1);

   rx_state_t       state;
   rx_state_t       next_state;
   logic [CW-1:0]   clk_cnt;
   logic [BW-1:0]   bit_cnt;
   logic [CW-1:0]   clk_term;
   logic            clk_clear;
   logic            clk_en;
   logic            bit_clear;
   logic            bit_en;

`ifndef RX_START_VERIFY_EN
   // The line level is only consulted by the start-bit verification.
   logic unused_serial;
   assign unused_serial = serial_in_sync;
`endif

   // Sample-period counter: half a bit in START, full bits in DATA.
   rx_bit_timer #(.WIDTH(CW), .WRAP(1'b1)) u_clk_timer (
      .clk      (clk),
      .rst      (rst),
      .clear    (clk_clear),
      .enable   (clk_en),
      .terminal (clk_term),
      .count    (clk_cnt)
   );

   // Strobed-bit counter: holds at DATA_BITS+1 until the next frame.
   rx_bit_timer #(.WIDTH(BW), .WRAP(1'b0)) u_bit_timer (
      .clk      (clk),
      .rst      (rst),
      .clear    (bit_clear),
      .enable   (bit_en),
      .terminal (BIT_TERM),
      .count    (bit_cnt)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and output decode from the registered state and counters.
   always_comb begin
      next_state    = state;
      shift_strobe  = 1'b0;
      sbc_clear     = 1'b0;
      sbc_enable    = 1'b0;
      load_buffer   = 1'b0;
      glitch_reject = 1'b0;
      rx_busy       = (state != IDLE);
      clk_term      = BIT_LAST;
      clk_clear     = 1'b0;
      clk_en        = 1'b0;
      bit_clear     = 1'b0;
      bit_en        = 1'b0;
      case (state)
         IDLE: begin
            clk_clear = 1'b1;
            bit_clear = 1'b1;
            if (start_bit_detected) begin
               next_state = START;
            end else begin
               next_state = IDLE;
            end
         end
         START: begin
            clk_term  = HALF_LAST;
            clk_en    = 1'b1;
            sbc_clear = (clk_cnt == '0);
            if (clk_cnt == HALF_LAST) begin
`ifdef RX_START_VERIFY_EN
               if (serial_in_sync) begin
                  glitch_reject = 1'b1;
                  next_state    = IDLE;
               end else begin
                  next_state = DATA;
               end
`else
               next_state = DATA;
`endif
            end else begin
               next_state = START;
            end
         end
         DATA: begin
            clk_en = 1'b1;
            if (clk_cnt == BIT_LAST) begin
               shift_strobe = 1'b1;
               bit_en       = 1'b1;
               if (bit_cnt == LAST_IDX) begin
                  next_state = STOP_CHK;
               end else begin
                  next_state = DATA;
               end
            end else begin
               next_state = DATA;
            end
         end
         STOP_CHK: begin
            sbc_enable = 1'b1;
            next_state = FRAME_EVAL;
         end
         FRAME_EVAL: begin
            if (framing_error) begin
               next_state = IDLE;
            end else begin
               next_state = LOAD;
            end
         end
         LOAD: begin
            load_buffer = 1'b1;
            next_state  = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_rx_seq_ctrl.sv
// Directed bench for rx_seq_ctrl with default parameters (10 clks/bit,
// 8 data bits). Outputs are compared every cycle against a cycle table.
module tb_rx_seq_ctrl;

   localparam int M_OK = 0;
   localparam int M_FE = 1;
   localparam int M_GL = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start_bit_detected = 1'b0;
   logic serial_in_sync = 1'b0;
   logic framing_error = 1'b0;
   logic shift_strobe, sbc_clear, sbc_enable, load_buffer, rx_busy, glitch_reject;

   int n_vec = 0;
   int n_bad = 0;

   rx_seq_ctrl dut (
      .clk                (clk),
      .rst                (rst),
      .start_bit_detected (start_bit_detected),
      .serial_in_sync     (serial_in_sync),
      .framing_error      (framing_error),
      .shift_strobe       (shift_strobe),
      .sbc_clear          (sbc_clear),
      .sbc_enable         (sbc_enable),
      .load_buffer        (load_buffer),
      .rx_busy            (rx_busy),
      .glitch_reject      (glitch_reject)
   );

   always #5 clk = ~clk;

   // Output vector: {glitch_reject, rx_busy, load_buffer, sbc_enable, sbc_clear, shift_strobe}
   function automatic logic [5:0] outs();
      return {glitch_reject, rx_busy, load_buffer, sbc_enable, sbc_clear, shift_strobe};
   endfunction

   task automatic check_vec(input string tag, input logic [5:0] got, input logic [5:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b (glitch,busy,load,en,clr,strobe)", tag, got, exp);
      end
   endtask

   // Expected outputs in cycle cyc of a frame (cycle 0 = first START cycle).
   function automatic logic [5:0] expect_out(input int mode, input int cyc);
      logic [5:0] e;
      e = 6'b000000;
`ifdef RX_START_VERIFY_EN
      if (mode == M_GL) begin
         if (cyc <= 4) e[4] = 1'b1;
         if (cyc == 0) e[1] = 1'b1;
         if (cyc == 4) e[5] = 1'b1;
         return e;
      end
`endif
      if (cyc == 0) e[1] = 1'b1;
      if (cyc >= 14 && cyc <= 94 && ((cyc - 14) % 10) == 0) e[0] = 1'b1;
      if (cyc == 95) e[2] = 1'b1;
      if (mode == M_FE) begin
         if (cyc <= 96) e[4] = 1'b1;
      end else begin
         if (cyc == 97) e[3] = 1'b1;
         if (cyc <= 97) e[4] = 1'b1;
      end
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start_bit_detected in IDLE; returns at frame cycle 0.
   task automatic start_frame();
      start_bit_detected = 1'b1;
      tick();
      start_bit_detected = 1'b0;
   endtask

   // Watch ncyc cycles of a frame; optionally pulse start mid-frame and/or
   // in the first IDLE cycle after LOAD (cycle 98).
   task automatic watch_frame(input int scen, input int mode, input int ncyc,
                              input bit extra, input bit chain);
      for (int cyc = 0; cyc < ncyc; cyc++) begin
         serial_in_sync     = (mode == M_GL) && (cyc == 4);
         framing_error      = (mode == M_FE) && (cyc == 96);
         start_bit_detected = (extra && (cyc == 30 || cyc == 60)) || (chain && cyc == 98);
         #1;
         check_vec($sformatf("s%0d_c%0d", scen, cyc), outs(), expect_out(mode, cyc));
         tick();
      end
      serial_in_sync     = 1'b0;
      framing_error      = 1'b0;
      start_bit_detected = 1'b0;
   endtask

   initial begin
      // 1: reset and idle
      #1;
      check_vec("s1_in_reset", outs(), 6'b000000);
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         check_vec($sformatf("s1_idle%0d", i), outs(), 6'b000000);
         tick();
      end

      // 2: clean frame
      start_frame();
      watch_frame(2, M_OK, 105, 1'b0, 1'b0);

      // 3: framing error
      start_frame();
      watch_frame(3, M_FE, 105, 1'b0, 1'b0);

      // 4: false start bit (full frame when the verify feature is off)
      start_frame();
      watch_frame(4, M_GL, 105, 1'b0, 1'b0);

      // 5: reset in cycle 40 of a frame, then a clean frame
      start_frame();
      watch_frame(5, M_OK, 40, 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      check_vec("s5_rst_async", outs(), 6'b000000);
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_vec($sformatf("s5_post%0d", i), outs(), 6'b000000);
         tick();
      end
      start_frame();
      watch_frame(50, M_OK, 105, 1'b0, 1'b0);

      // 6: ignored mid-frame pulses, then a back-to-back frame
      start_frame();
      watch_frame(6, M_OK, 99, 1'b1, 1'b1);
      watch_frame(60, M_OK, 105, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
